// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode/funct fields for the M extension,
// RV32M funct3 selectors, muldiv FSM state encoding and op-sign decode.
package riscv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. Operands are reduced
// to magnitudes on acceptance, one radix-2 step runs per cycle in a shared
// 2*XLEN accumulator, and the sign is applied when the last step completes.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int AW = 2 * XLEN;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [AW-1:0]   ONE_A  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);

  // two's complement negate when neg is set (XLEN wide)
  function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v) + ONE_X : v;
  endfunction

  // two's complement negate when neg is set (2*XLEN wide)
  function automatic logic [AW-1:0] negate_a(input logic [AW-1:0] v, input logic neg);
    return neg ? (~v) + ONE_A : v;
  endfunction

  // absolute value when the operand is interpreted as signed
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return negate_x(v, sgn && v[XLEN-1]);
  endfunction

  state_t          state, state_next;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] mag_q;        // multiplicand for mul, divisor for div
  logic [AW-1:0]   acc;          // product, or remainder:quotient
  logic [AW-1:0]   acc_step;
  logic [CW-1:0]   cnt;
  logic            neg_q;        // product / quotient sign
  logic            neg_r;        // remainder sign
  logic            accept, finish;
  logic            in_sa, in_sb, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res, final_res;
  logic [XLEN:0]   add_sum, sub_diff;
  logic [AW-1:0]   prod;

  // decode incoming operands and detect the single-cycle divide cases
  always_comb begin
    in_sa    = op_signed_a(i_funct3);
    in_sb    = op_signed_b(i_funct3);
    a_mag    = magnitude(i_op_a, in_sa);
    b_mag    = magnitude(i_op_b, in_sb);
    div_zero = i_funct3[2] && (i_op_b == ZERO_X);
    div_ovf  = i_funct3[2] && in_sa && (i_op_a == MIN_X) && (i_op_b == ONES_X);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_res = i_funct3[1] ? i_op_a : ONES_X;
    end else begin
      special_res = i_funct3[1] ? ZERO_X : MIN_X;
    end
  end

  // one radix-2 iteration plus the sign-corrected result of that iteration
  always_comb begin
    add_sum  = {1'b0, acc[AW-1:XLEN]} + {1'b0, (acc[0] ? mag_q : ZERO_X)};
    sub_diff = acc[AW-1:XLEN-1] - {1'b0, mag_q};
    prod     = ZERO_X;
    if (funct3_q[2]) begin
      if (!sub_diff[XLEN]) begin
        acc_step = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {acc[AW-2:0], 1'b0};
      end
      if (funct3_q[1]) begin
        final_res = negate_x(acc_step[AW-1:XLEN], neg_r);
      end else begin
        final_res = negate_x(acc_step[XLEN-1:0], neg_q);
      end
    end else begin
      acc_step = {add_sum, acc[XLEN-1:1]};
      prod     = negate_a(acc_step, neg_q);
      if (funct3_q == F3_MUL) begin
        final_res = prod[XLEN-1:0];
      end else begin
        final_res = prod[AW-1:XLEN];
      end
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          accept     = 1'b1;
          state_next = special ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_ONE) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    o_stall = !i_rst && (((state == ST_IDLE) && i_start && !i_flush) || (state == ST_RUN));
    o_done  = (state == ST_DONE);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else if (i_flush) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      funct3_q <= 3'b000;
      mag_q    <= ZERO_X;
      acc      <= {AW{1'b0}};
      cnt      <= {CW{1'b0}};
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_result <= ZERO_X;
    end else if (accept) begin
      funct3_q <= i_funct3;
      mag_q    <= i_funct3[2] ? b_mag : a_mag;
      acc      <= {ZERO_X, (i_funct3[2] ? a_mag : b_mag)};
      cnt      <= CNT_INIT;
      neg_q    <= (in_sa && i_op_a[XLEN-1]) ^ (in_sb && i_op_b[XLEN-1]);
      neg_r    <= in_sa && i_op_a[XLEN-1];
      if (special) begin
        o_result <= special_res;
      end
    end else if ((state == ST_RUN) && !i_flush) begin
      acc <= acc_step;
      cnt <= cnt - CNT_ONE;
      if (finish) begin
        o_result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of RV32M vectors with
// expected results, a few randomised ops against a reference model, and
// hand-written flush / reset / back-to-back sequences.
module tb_ex_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, done;
  logic [31:0] result;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;
  vec_t        vecs[20];

  ex_muldiv_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
    .i_funct3(funct3), .i_op_a(op_a), .i_op_b(op_b),
    .o_stall(stall), .o_done(done), .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // independent reference built on native 64-bit and int arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int ia, ib;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'h0, a};       zb = {32'h0, b};
    ia = a; ib = b;
    case (f3)
      MUL:    begin p = za * zb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * zb; return p[63:32]; end
      MULHU:  begin p = za * zb; return p[63:32]; end
      DIV:    return (b == 32'h0) ? 32'hFFFFFFFF :
                     ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib));
      DIVU:   return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      REM:    return (b == 32'h0) ? a :
                     ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib));
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // issue one op with start held through DONE; check stall length, done timing and result
  task automatic do_op(input vec_t v);
    int cyc = 0, stall_cnt = 0, done_cnt = 0, first_done = -1;
    int exp_stall;
    logic [31:0] e;
    exp_stall = v.special ? 1 : 33;
    @(negedge clk);
    start = 1'b1; funct3 = v.f3; op_a = v.a; op_b = v.b;
    exp_q.push_back(v.exp);
    while (cyc < 60) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++;
        first_done = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("result f3=%0d a=%08h b=%08h", v.f3, v.a, v.b), result, e);
          last_res = e;
        end
        break;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        op_a = $urandom; op_b = $urandom;
      end
    end
    if (done_cnt == 0) begin
      chk("done_timeout", 32'h0, 32'h1);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("done_cycle", 32'(first_done), 32'(exp_stall));
  endtask

  // start low for one cycle: no repeat done, no stall
  task automatic idle_check();
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_no_done", {31'h0, done}, 32'h0);
    chk("idle_no_stall", {31'h0, stall}, 32'h0);
  endtask

  initial begin
    vec_t rv;
    int   d_cnt, s_cnt;

    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{REM,    32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[13] = '{DIV,    32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    vecs[14] = '{DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[15] = '{REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[16] = '{DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[17] = '{REMU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[18] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[19] = '{REMU,   32'd7,        32'd0,        32'd7,        1'b1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = 32'h0; op_b = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i]);
      idle_check();
    end

    // randomised ops against the reference model
    for (int i = 0; i < 8; i++) begin
      rv.f3 = 3'($urandom_range(0, 7));
      rv.a  = $urandom;
      rv.b  = (i < 3) ? 32'($urandom_range(1, 300)) : $urandom;
      rv.exp = model(rv.f3, rv.a, rv.b);
      rv.special = rv.f3[2] && ((rv.b == 32'h0) ||
                   (!rv.f3[0] && rv.a == 32'h80000000 && rv.b == 32'hFFFFFFFF));
      do_op(rv);
      idle_check();
    end

    // back-to-back MULs: second accepted in the IDLE cycle after DONE
    rv = '{MUL, 32'd12, 32'd11, 32'd132, 1'b0};
    do_op(rv);
    rv = '{MUL, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFF7, 1'b0};
    do_op(rv);
    idle_check();

    // flush in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = MUL; op_a = 32'd3; op_b = 32'd4;
    #1;
    chk("flush_idle_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_done", {31'h0, done}, 32'h0);
    chk("flush_idle_stall2", {31'h0, stall}, 32'h0);

    // flush in RUN cycle 10: no done, result unchanged
    @(negedge clk);
    start = 1'b1; funct3 = MUL; op_a = 32'd5; op_b = 32'd6;
    exp_q.push_back(32'd30);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    void'(exp_q.pop_back());
    d_cnt = 0; s_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done) d_cnt++;
      if (stall) s_cnt++;
      @(negedge clk);
    end
    chk("flush_run_done", 32'(d_cnt), 32'h0);
    chk("flush_run_stall", 32'(s_cnt), 32'h0);
    chk("flush_run_result", result, last_res);

    // reset mid-RUN clears everything and forces stall low
    @(negedge clk);
    start = 1'b1; funct3 = DIVU; op_a = 32'd1000; op_b = 32'd3;
    exp_q.push_back(32'd333);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_forces_stall_low", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    chk("rst_mid_result", result, 32'h0);

    // normal operation after reset
    rv = '{DIVU, 32'd1000, 32'd3, 32'd333, 1'b0};
    do_op(rv);
    idle_check();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
